// File: rtl/csr_trap_sequencer_pkg.sv
// Shared definitions for the user-mode CSR trap sequencer: FSM states,
// CSR addresses, ustatus bit positions and trap cause codes.
package csr_trap_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STATUS,
    T_VEC,
    U_STATUS,
    REDIR
  } stateE;

  localparam logic [11:0] CSR_USTATUS = 12'h000;
  localparam logic [11:0] CSR_UTVEC   = 12'h005;
  localparam logic [11:0] CSR_UEPC    = 12'h041;
  localparam logic [11:0] CSR_UCAUSE  = 12'h042;
  localparam logic [11:0] CSR_UTVAL   = 12'h043;

  localparam int unsigned USTATUS_UIE  = 0;
  localparam int unsigned USTATUS_UPIE = 4;

  localparam logic [3:0] CAUSE_FETCH_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INST     = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

endpackage

// File: rtl/csr_trap_sequencer_trap_target_calc.sv
// Trap redirect target from UTVEC. Vectored interrupt dispatch is built in
// only when VECTORED_TRAP_EN is defined; otherwise the mode bits are ignored.
module trap_target_calc
  import csr_trap_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] iUtvec,
  input  logic            iIsIrq,
  input  logic [3:0]      iCause,
  output logic [XLEN-1:0] oTarget
);

  logic [XLEN-1:0] base;

  assign base = {iUtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
  always_comb begin
    oTarget = base;
    if (iIsIrq && (iUtvec[1:0] == 2'b01))
      oTarget = base + XLEN'({iCause, 2'b00});
  end
`else
  logic unusedModeBits;
  assign unusedModeBits = ^{iUtvec[1:0], iIsIrq, iCause};
  assign oTarget = base;
`endif

endmodule

// File: rtl/csr_trap_sequencer.sv
// Owner of the user-mode CSR file write port: trap entry, uret return and
// datapath CSR-instruction writes. Optional macro: VECTORED_TRAP_EN.
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iTrapReq,
  input  logic              iTrapIsIrq,
  input  logic [3:0]        iTrapCause,
  input  logic [XLEN-1:0]   iTrapPC,
  input  logic [XLEN-1:0]   iTrapVal,
  input  logic              iUret,
  input  logic              iCsrWrReq,
  input  logic [CSR_AW-1:0] iCsrWrAddr,
  input  logic [XLEN-1:0]   iCsrWrData,
  output logic              oCsrWrAck,
  output logic              oCsrWe,
  output logic [CSR_AW-1:0] oCsrAddr,
  output logic [XLEN-1:0]   oCsrWData,
  output logic [CSR_AW-1:0] oCsrRdAddr,
  input  logic [XLEN-1:0]   iCsrRdData,
  output logic              oPCLoad,
  output logic [XLEN-1:0]   oPCTarget,
  output logic              oStall,
  output logic              oTrapAck,
  output logic              oOverrun
);

  stateE           state, stateNext;
  logic [3:0]      causeQ;
  logic            isIrqQ;
  logic [XLEN-1:0] pcQ, valQ, targetQ;
  logic            overrunQ;
  logic            secondHalf;
  logic [XLEN-1:0] statusSnap, statusRd, vecTarget;
  logic            idle, trapStart, uretStart, csrInstWr;

  assign idle      = (state == IDLE);
  assign trapStart = ~iRST & idle & iTrapReq;
  assign uretStart = ~iRST & idle & ~iTrapReq & iUret;
  assign csrInstWr = ~iRST & idle & ~iTrapReq & ~iUret & iCsrWrReq;

  trap_target_calc #(.XLEN(XLEN)) uTargetCalc (
    .iUtvec (iCsrRdData),
    .iIsIrq (isIrqQ),
    .iCause (causeQ),
    .oTarget(vecTarget)
  );

  // U_STATUS shares the read port: USTATUS in the first half (snapshotted at
  // the falling edge), UEPC in the second half, captured as target at the rise.
  assign statusRd = secondHalf ? statusSnap : iCsrRdData;

  always_comb begin
    stateNext  = state;
    oCsrWe     = 1'b0;
    oCsrWrAck  = 1'b0;
    oCsrAddr   = '0;
    oCsrWData  = '0;
    oCsrRdAddr = CSR_AW'(CSR_USTATUS);
    case (state)
      IDLE: begin
        if (trapStart) begin
          stateNext = T_EPC;
        end else if (uretStart) begin
          stateNext = U_STATUS;
        end else if (csrInstWr) begin
          oCsrWe    = 1'b1;
          oCsrWrAck = 1'b1;
          oCsrAddr  = iCsrWrAddr;
          oCsrWData = iCsrWrData;
        end
      end
      T_EPC: begin
        oCsrWe    = 1'b1;
        oCsrAddr  = CSR_AW'(CSR_UEPC);
        oCsrWData = pcQ;
        stateNext = T_CAUSE;
      end
      T_CAUSE: begin
        oCsrWe               = 1'b1;
        oCsrAddr             = CSR_AW'(CSR_UCAUSE);
        oCsrWData[XLEN-1]    = isIrqQ;
        oCsrWData[3:0]       = causeQ;
        stateNext            = T_TVAL;
      end
      T_TVAL: begin
        oCsrWe    = 1'b1;
        oCsrAddr  = CSR_AW'(CSR_UTVAL);
        oCsrWData = valQ;
        stateNext = T_STATUS;
      end
      T_STATUS: begin
        oCsrWe                  = 1'b1;
        oCsrAddr                = CSR_AW'(CSR_USTATUS);
        oCsrRdAddr              = CSR_AW'(CSR_USTATUS);
        oCsrWData               = iCsrRdData;
        oCsrWData[USTATUS_UPIE] = iCsrRdData[USTATUS_UIE];
        oCsrWData[USTATUS_UIE]  = 1'b0;
        stateNext               = T_VEC;
      end
      T_VEC: begin
        oCsrRdAddr = CSR_AW'(CSR_UTVEC);
        stateNext  = REDIR;
      end
      U_STATUS: begin
        oCsrWe                  = 1'b1;
        oCsrAddr                = CSR_AW'(CSR_USTATUS);
        oCsrRdAddr              = secondHalf ? CSR_AW'(CSR_UEPC) : CSR_AW'(CSR_USTATUS);
        oCsrWData               = statusRd;
        oCsrWData[USTATUS_UIE]  = statusRd[USTATUS_UPIE];
        oCsrWData[USTATUS_UPIE] = 1'b1;
        stateNext               = REDIR;
      end
      REDIR:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      causeQ   <= '0;
      isIrqQ   <= 1'b0;
      pcQ      <= '0;
      valQ     <= '0;
      targetQ  <= '0;
      overrunQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (trapStart) begin
        causeQ <= iTrapCause;
        isIrqQ <= iTrapIsIrq;
        pcQ    <= iTrapPC;
        valQ   <= iTrapVal;
      end
      if (state == T_VEC)
        targetQ <= vecTarget;
      else if (state == U_STATUS)
        targetQ <= iCsrRdData;
      if (!idle && (iTrapReq || iUret))
        overrunQ <= 1'b1;
    end
  end

  always_ff @(negedge iCLK or posedge iRST) begin
    if (iRST) begin
      secondHalf <= 1'b0;
      statusSnap <= '0;
    end else begin
      secondHalf <= (state == U_STATUS);
      if ((state == U_STATUS) && !secondHalf)
        statusSnap <= iCsrRdData;
    end
  end

  assign oPCLoad   = (state == REDIR);
  assign oPCTarget = targetQ;
  assign oStall    = ~iRST & (~idle | iTrapReq | iUret);
  assign oTrapAck  = trapStart;
  assign oOverrun  = overrunQ;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed plus randomized bench for csr_trap_sequencer against a CSR-level
// reference model; honours VECTORED_TRAP_EN the same way as the design.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trapReq, trapIsIrq, uret, csrWrReq;
  logic [3:0]  trapCause;
  logic [31:0] trapPC, trapVal, csrWrData, csrWData, csrRdData, pcTarget;
  logic [11:0] csrWrAddr, csrAddr, csrRdAddr;
  logic        csrWrAck, csrWe, pcLoad, stall, trapAck, overrun;

  logic [31:0] csrMem [0:4095];
  int          wrCnt  [0:4095];

  int nCmp = 0;
  int nErr = 0;

  logic [31:0] mStatus, mTvec, mEpc, mCause, mTval;
  logic        mOverrun;

  csr_trap_sequencer #(.XLEN(32), .CSR_AW(12)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iTrapReq  (trapReq),
    .iTrapIsIrq(trapIsIrq),
    .iTrapCause(trapCause),
    .iTrapPC   (trapPC),
    .iTrapVal  (trapVal),
    .iUret     (uret),
    .iCsrWrReq (csrWrReq),
    .iCsrWrAddr(csrWrAddr),
    .iCsrWrData(csrWrData),
    .oCsrWrAck (csrWrAck),
    .oCsrWe    (csrWe),
    .oCsrAddr  (csrAddr),
    .oCsrWData (csrWData),
    .oCsrRdAddr(csrRdAddr),
    .iCsrRdData(csrRdData),
    .oPCLoad   (pcLoad),
    .oPCTarget (pcTarget),
    .oStall    (stall),
    .oTrapAck  (trapAck),
    .oOverrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (csrWe) begin
      csrMem[csrAddr] <= csrWData;
      wrCnt[csrAddr]  <= wrCnt[csrAddr] + 1;
    end
  end

  assign csrRdData = csrMem[csrRdAddr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expTarget(input logic [31:0] tvec, input logic irq,
                                            input logic [3:0] cause);
    logic [31:0] t;
    t = tvec - (tvec % 4);
`ifdef VECTORED_TRAP_EN
    if ((tvec % 4 == 1) && irq) t = t + 32'(cause) * 4;
`endif
    return t;
  endfunction

  task automatic modelWrite(input logic [11:0] addr, input logic [31:0] data);
    case (addr)
      12'h000: mStatus = data;
      12'h005: mTvec   = data;
      12'h041: mEpc    = data;
      12'h042: mCause  = data;
      12'h043: mTval   = data;
      default: ;
    endcase
  endtask

  task automatic checkCsrs(input string tag);
    chk({tag, ".ustatus"}, csrMem[12'h000], mStatus);
    chk({tag, ".uepc"},    csrMem[12'h041], mEpc);
    chk({tag, ".ucause"},  csrMem[12'h042], mCause);
    chk({tag, ".utval"},   csrMem[12'h043], mTval);
  endtask

  task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
    csrWrReq = 1'b1; csrWrAddr = addr; csrWrData = data;
    #1;
    chk("wr.ack",   32'(csrWrAck), 32'd1);
    chk("wr.we",    32'(csrWe),    32'd1);
    chk("wr.addr",  32'(csrAddr),  32'(addr));
    chk("wr.stall", 32'(stall),    32'd0);
    @(posedge clk); #1;
    csrWrReq = 1'b0;
    modelWrite(addr, data);
    chk("wr.mem", csrMem[addr], data);
  endtask

  task automatic doTrap(input logic [3:0] cause, input logic irq, input logic [31:0] pc,
                        input logic [31:0] val, input bit withCsr, input bit midReq);
    int          c40;
    logic [31:0] tgt;
    c40 = wrCnt[12'h040];
    tgt = expTarget(mTvec, irq, cause);
    trapReq = 1'b1; trapIsIrq = irq; trapCause = cause; trapPC = pc; trapVal = val;
    if (withCsr) begin
      csrWrReq = 1'b1; csrWrAddr = 12'h040; csrWrData = 32'hDEAD_BEEF;
    end
    #1;
    chk("trap.c0.ack",   32'(trapAck),  32'd1);
    chk("trap.c0.stall", 32'(stall),    32'd1);
    chk("trap.c0.wrAck", 32'(csrWrAck), 32'd0);
    chk("trap.c0.we",    32'(csrWe),    32'd0);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      csrWrReq = 1'b0;
      trapReq  = midReq && (c == 2);
      if (trapReq) begin
        trapCause = 4'($urandom); trapPC = $urandom; trapVal = $urandom; trapIsIrq = ~irq;
      end
      #1;
      if (c <= 6) begin
        chk("trap.stall",  32'(stall),   32'd1);
        chk("trap.we",     32'(csrWe),   32'(c <= 4));
        chk("trap.pcLoad", 32'(pcLoad),  32'(c == 6));
        chk("trap.ack",    32'(trapAck), 32'd0);
        if (c == 6) chk("trap.target", pcTarget, tgt);
      end else begin
        chk("trap.c7.stall",  32'(stall),  32'd0);
        chk("trap.c7.pcLoad", 32'(pcLoad), 32'd0);
      end
    end
    mEpc    = pc;
    mCause  = {irq, 27'b0, cause};
    mTval   = val;
    mStatus = (mStatus & ~32'h11) | (mStatus[0] ? 32'h10 : 32'h0);
    if (midReq) mOverrun = 1'b1;
    checkCsrs("trap");
    if (withCsr) chk("trap.squash", 32'(wrCnt[12'h040]), 32'(c40));
    chk("trap.overrun", 32'(overrun), 32'(mOverrun));
  endtask

  task automatic doUret();
    logic [31:0] tgt;
    tgt = mEpc;
    uret = 1'b1;
    #1;
    chk("uret.c0.stall", 32'(stall),   32'd1);
    chk("uret.c0.we",    32'(csrWe),   32'd0);
    chk("uret.c0.ack",   32'(trapAck), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      uret = 1'b0;
      #1;
      chk("uret.stall",  32'(stall),  32'(c <= 2));
      chk("uret.we",     32'(csrWe),  32'(c == 1));
      chk("uret.pcLoad", 32'(pcLoad), 32'(c == 2));
      if (c == 1) chk("uret.addr", 32'(csrAddr), 32'h000);
      if (c == 2) chk("uret.target", pcTarget, tgt);
    end
    mStatus = (mStatus & ~32'h11) | (mStatus[4] ? 32'h1 : 32'h0) | 32'h10;
    checkCsrs("uret");
  endtask

  initial begin
    int          sel;
    int          c43;
    logic [11:0] addrList [5];
    addrList = '{12'h000, 12'h005, 12'h041, 12'h042, 12'h043};
    rst = 1'b1; trapReq = 0; trapIsIrq = 0; trapCause = 0; trapPC = 0; trapVal = 0;
    uret = 0; csrWrReq = 0; csrWrAddr = 0; csrWrData = 0; mOverrun = 1'b0;
    mStatus = 0; mTvec = 0; mEpc = 0; mCause = 0; mTval = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall",   32'(stall),   32'd0);
    chk("rst.we",      32'(csrWe),   32'd0);
    chk("rst.pcLoad",  32'(pcLoad),  32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.target",  pcTarget,     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    csrWrite(12'h000, 32'h1);
    csrWrite(12'h005, 32'h100);
    csrWrite(12'h041, 32'h0);
    csrWrite(12'h042, 32'h0);
    csrWrite(12'h043, 32'h0);

    doTrap(4'd2, 1'b0, 32'h40, 32'h73, 1'b0, 1'b0);
    chk("t1.ustatus", csrMem[12'h000], 32'h10);
    chk("t1.uepc",    csrMem[12'h041], 32'h40);
    chk("t1.ucause",  csrMem[12'h042], 32'h2);
    chk("t1.utval",   csrMem[12'h043], 32'h73);

    doUret();
    chk("u1.ustatus", csrMem[12'h000], 32'h11);

    doTrap(4'd6, 1'b0, 32'h1234, 32'h5678, 1'b1, 1'b0);
    doTrap(4'd0, 1'b0, 32'h2000, 32'h2004, 1'b0, 1'b1);
    chk("ovr.set", 32'(overrun), 32'd1);
    doUret();
    chk("ovr.sticky", 32'(overrun), 32'd1);

    // reset while the sequence sits in T_TVAL
    trapReq = 1'b1; trapIsIrq = 0; trapCause = 4'd4; trapPC = 32'h3000; trapVal = 32'hCAFE;
    @(posedge clk); #1;
    trapReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    c43 = wrCnt[12'h043];
    rst = 1'b1;
    #1;
    chk("rstmid.stall",   32'(stall),    32'd0);
    chk("rstmid.we",      32'(csrWe),    32'd0);
    chk("rstmid.wdata",   csrWData,      32'd0);
    chk("rstmid.addr",    32'(csrAddr),  32'd0);
    chk("rstmid.pcLoad",  32'(pcLoad),   32'd0);
    chk("rstmid.target",  pcTarget,      32'd0);
    chk("rstmid.overrun", 32'(overrun),  32'd0);
    chk("rstmid.ack",     32'(trapAck),  32'd0);
    mOverrun = 1'b0;
    mEpc = 32'h3000; mCause = 32'h4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rstmid.noTval", 32'(wrCnt[12'h043]), 32'(c43));
    chk("rstmid.idle",   32'(stall),          32'd0);
    checkCsrs("rstmid");
    doTrap(4'd2, 1'b0, 32'h44, 32'h77, 1'b0, 1'b0);

    csrWrite(12'h005, 32'h201);
    doTrap(4'd4, 1'b1, 32'h500, 32'h0, 1'b0, 1'b0);
    doTrap(4'd4, 1'b0, 32'h504, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: csrWrite(addrList[$urandom_range(0, 4)], $urandom);
        1: doTrap(4'($urandom), 1'($urandom), $urandom, $urandom,
                  1'($urandom), ($urandom_range(0, 3) == 0));
        2: doUret();
        default: csrWrite(12'h300 + 12'($urandom_range(0, 15)), $urandom);
      endcase
    end
    chk("final.overrun", 32'(overrun), 32'(mOverrun));
    checkCsrs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/csr_trap_sequencer.md
# csr_trap_sequencer

Multi-cycle controller that owns the single write port of the user-mode CSR register file. It sequences trap entry (uepc, ucause, utval, ustatus updates, then a PC redirect to utvec) and `uret` return (ustatus restore, then a PC redirect to uepc). It arbitrates those sequences against CSR-instruction writes from the datapath, and stalls the core while a sequence runs. It sits between the control unit and exception sources on one side and the CSR file and PC logic on the other.

## Interface
Parameters:
- XLEN, 32, data/PC width
- CSR_AW, 12, CSR address width

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iTrapReq  in  1  trap request, sampled in IDLE only
- iTrapIsIrq  in  1  request is an interrupt (ucause bit 31)
- iTrapCause  in  4  cause code
- iTrapPC  in  XLEN  PC of the faulting instruction
- iTrapVal  in  XLEN  utval value (faulting instruction or address)
- iUret  in  1  `uret` executing
- iCsrWrReq  in  1  CSR instruction write request
- iCsrWrAddr  in  CSR_AW  CSR instruction target
- iCsrWrData  in  XLEN  CSR instruction write data
- oCsrWrAck  out  1  instruction write performed this cycle
- oCsrWe  out  1  CSR file write enable
- oCsrAddr  out  CSR_AW  CSR file write address
- oCsrWData  out  XLEN  CSR file write data
- oCsrRdAddr  out  CSR_AW  CSR file read address (combinational read)
- iCsrRdData  in  XLEN  CSR file read data
- oPCLoad  out  1  one-cycle PC redirect strobe
- oPCTarget  out  XLEN  redirect target
- oStall  out  1  freeze the pipeline
- oTrapAck  out  1  trap captured
- oOverrun  out  1  sticky flag: request arrived while busy

## Operation
- CSR addresses: USTATUS 0x000, UTVEC 0x005, UEPC 0x041, UCAUSE 0x042, UTVAL 0x043. ustatus bit 0 is UIE; bit 4 is UPIE.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_VEC, U_STATUS, REDIR.
- Priority in IDLE: iTrapReq > iUret > iCsrWrReq.
- Trap in IDLE:
  - Latch cause, isIrq, PC and val; pulse oTrapAck; go to T_EPC.
  - T_EPC writes UEPC=PC. T_CAUSE writes UCAUSE={isIrq,27'b0,cause}. T_TVAL writes UTVAL=val.
  - T_STATUS reads USTATUS and writes it back with UPIE=old UIE, UIE=0, other bits unchanged.
  - T_VEC reads UTVEC and registers the target. Then REDIR.
- uret in IDLE: go to U_STATUS.
  - U_STATUS reads USTATUS and writes it back with UIE=old UPIE, UPIE=1.
  - U_STATUS also reads UEPC and registers it as the target. The read port is time-shared: the USTATUS read is combinational for the write data, and the UEPC read happens in the second half via registered address muxing.
  - Then REDIR.
- REDIR: oPCLoad=1, oPCTarget=registered target, next state IDLE.
- CSR instruction write in IDLE with no trap or uret: oCsrWe=1, address and data forwarded, oCsrWrAck=1 in the same cycle.
  - If a trap or uret is present in the same cycle, the instruction write is dropped (oCsrWrAck=0); it is squashed.
- iTrapReq or iUret outside IDLE: ignored and oOverrun set. oOverrun clears only on reset.
- Reset at any point: state IDLE; all outputs 0 and oOverrun 0; latched fields 0. No further writes of an aborted sequence occur.

## Timing
- Trap captured in cycle 0: writes in cycles 1–4, UTVEC read in cycle 5, oPCLoad in cycle 6, ready for a new request in cycle 7.
- uret in cycle 0: status write in cycle 1, oPCLoad in cycle 2.
- oStall = (state≠IDLE) | iTrapReq | iUret, combinational. It is high from cycle 0 through the REDIR cycle inclusive.
- oCsrWe is high exactly one cycle per write state. In all other non-IDLE states it is 0.
- oPCTarget is registered and holds its last value; it is valid only while oPCLoad=1.

## Configuration
- VECTORED_TRAP_EN defined: if UTVEC[1:0]==2'b01 and isIrq, target={UTVEC[31:2],2'b00}+(cause<<2). Otherwise target={UTVEC[31:2],2'b00}.
- VECTORED_TRAP_EN undefined: target is always {UTVEC[31:2],2'b00}; mode bits are ignored.

## Structure
- Shared package: state enum, CSR address constants, ustatus bit indices, cause codes (ILLEGAL_INST=2, misaligned fetch=0, load misaligned=4, store misaligned=6).
- One sub-module: trap_target_calc. It is combinational, takes UTVEC, isIrq and cause, produces the target, and contains the VECTORED_TRAP_EN logic.

## Test plan
- Illegal-instruction trap: iTrapCause=2, iTrapPC=0x0000_0040, iTrapVal=0x0000_0073, UTVEC=0x0000_0100, ustatus=0x1 -> UEPC=0x40, UCAUSE=0x2, UTVAL=0x73, ustatus=0x10, oPCLoad with target 0x100 in cycle 6; oStall high cycles 0–6.
- uret after the above -> ustatus=0x11; oPCLoad with target 0x40 in cycle 2.
- iCsrWrReq (addr 0x040, data 0xDEAD_BEEF) asserted together with iTrapReq -> no write to 0x040; oCsrWrAck=0; trap sequence proceeds.
- Second iTrapReq during T_CAUSE -> ignored; oOverrun=1 sticky; sequence completes unchanged.
- iRST asserted in T_TVAL -> all outputs 0 immediately; UTVAL not written afterwards; next trap runs a full sequence.
- VECTORED_TRAP_EN: UTVEC=0x0000_0201, isIrq=1, cause=4 -> target 0x210. With isIrq=0 -> target 0x200.
